// File: rtl/uart_frame_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_tx_pkg
//
// Shared definitions for the CatCore UART command path. The transmitter
// (uart_frame_tx) and the command decoder use this one package so that
// the frame size, the FSM state codes and the command characters are
// defined in exactly one place.
//
// Contents:
//   FRAME_BYTES / DBITS / FRAME_BITS - CatCore frame geometry
//   ST_*                             - transmitter FSM state codes
//   cmd_char_e                       - command characters
//   build_frame()                    - {cmd, payload, cmd} frame builder
// ---------------------------------------------------------------------------
package uart_frame_tx_pkg;

    // A CatCore frame is {cmd, 16 payload bytes, cmd}. The protocol fixes
    // this at 18 bytes; no other size is supported.
    localparam int FRAME_BYTES = 18;
    localparam int DBITS       = 8;
    localparam int FRAME_BITS  = FRAME_BYTES * DBITS;

    // Transmitter FSM state codes, kept as plain constants so older
    // blocks that compare against raw codes continue to work.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Command characters understood by the decoder.
    typedef enum logic [7:0] {
        CMD_AT = 8'h40,  // '@'
        CMD_A  = 8'h41,  // 'A'
        CMD_B  = 8'h42,  // 'B'
        CMD_C  = 8'h43,  // 'C'
        CMD_D  = 8'h44,  // 'D'
        CMD_G  = 8'h47,  // 'G'
        CMD_LA = 8'h61,  // 'a'
        CMD_LB = 8'h62   // 'b'
    } cmd_char_e;

    // Frame layout: the command byte occupies both the top byte (sent
    // first) and the bottom byte (sent last); payload[127:120] follows the
    // leading command byte on the wire.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [7:0]   cmd,
        input logic [127:0] payload
    );
        return {cmd, payload, cmd};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//
// Bit-period timer for the UART transmitter. A prescaler counts clk_ext
// cycles up to BR_LIMIT (one oversample tick); an oversample counter
// counts ticks up to OVERSAMPLE. bit_tick pulses for one cycle on the last
// clock of every bit period, so a bit period is BR_LIMIT*OVERSAMPLE clocks.
//
// Ports:
//   clk_ext  in  1  system clock
//   reset    in  1  asynchronous, active-high
//   clear    in  1  holds both counters at zero; releasing it starts a
//                   fresh bit period on the next clock
//   bit_tick out 1  one-cycle pulse at the end of each bit period
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int BR_LIMIT   = 672,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk_ext,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    // A limit of 1 would give a zero-width counter; keep at least one bit.
    localparam int TW = (BR_LIMIT   > 1) ? $clog2(BR_LIMIT)   : 1;
    localparam int OW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(BR_LIMIT - 1);
    localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);

    logic [TW-1:0] tick_cnt;
    logic [OW-1:0] os_cnt;
    logic          tick_end;
    logic          os_end;

    assign tick_end = (tick_cnt == TICK_LAST);
    assign os_end   = (os_cnt == OS_LAST);

    // Counters reset to zero at their terminal values; they never run past
    // them, so no wrap relies on the counter width.
    always_ff @(posedge clk_ext or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
        end else if (tick_end) begin
            tick_cnt <= '0;
            if (os_end) begin
                os_cnt <= '0;
            end else begin
                os_cnt <= os_cnt + 1'b1;
            end
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign bit_tick = tick_end && os_end && !clear;

endmodule

// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
//
// CatCore frame transmitter. On an accepted start the command byte and the
// 16-byte payload are latched as the 18-byte frame {cmd, payload, cmd} and
// sent 8N1 (start 0, data LSB first, stop 1) on tx, top byte first.
// Optional idle-high gap bit periods separate consecutive bytes.
//
// Handshake: start is a single-cycle request. It is accepted only while
// the FSM is in IDLE; tx falls on the following cycle and busy stays high
// until the final stop bit completes. The cycle after the last stop bit
// is the DONE cycle: done pulses, busy is low, and a start seen then is
// still refused (dropped pulses). Any start refused while a frame is in
// flight raises dropped combinationally in that same cycle and has no
// effect on the frame; cmd/payload are only looked at on acceptance.
//
// Ports:
//   clk_ext   in  1    system clock
//   reset     in  1    asynchronous, active-high; tx returns high at once
//   start     in  1    frame request
//   cmd       in  8    command character
//   payload   in  128  payload bytes, payload[127:120] sent first
//   tx        out 1    serial line, idle high
//   busy      out 1    frame in progress (START/DATA/STOP/GAP)
//   done      out 1    one-cycle pulse after the final stop bit
//   dropped   out 1    one-cycle pulse for each refused start
//   state_dbg out 3    current FSM state code (ST_* in the package)
// ---------------------------------------------------------------------------
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int BR_LIMIT   = 672,
    parameter int OVERSAMPLE = 16,
    parameter int GAP_BITS   = 0
) (
    input  logic         clk_ext,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   cmd,
    input  logic [127:0] payload,
    output logic         tx,
    output logic         busy,
    output logic         done,
    output logic         dropped,
    output logic [2:0]   state_dbg
);

    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [4:0]    BYTE_TOP  = 5'(FRAME_BYTES - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DBITS - 1);

    logic [2:0]            state;
    logic [FRAME_BITS-1:0] frame_q;
    logic [4:0]            byte_idx;
    logic [2:0]            bit_idx;
    logic [GW-1:0]         gap_cnt;
    logic                  bit_tick;
    logic                  baud_clear;

    // The baud timer is held cleared while idle (and in DONE), so the first
    // bit period starts exactly on the clock after acceptance and the frame
    // timing is locked to start rather than to a free-running counter.
    assign baud_clear = (state == ST_IDLE) || (state == ST_DONE);

    uart_baud_tick #(
        .BR_LIMIT   (BR_LIMIT),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .clk_ext  (clk_ext),
        .reset    (reset),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk_ext or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            frame_q  <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        frame_q  <= build_frame(cmd, payload);
                        byte_idx <= BYTE_TOP;
                        bit_idx  <= '0;
                        gap_cnt  <= '0;
                        state    <= ST_START;
                    end
                end

                ST_START: begin
                    if (bit_tick) begin
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == BIT_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (bit_tick) begin
                        bit_idx <= '0;
                        if (byte_idx == 5'd0) begin
                            state <= ST_DONE;
                        end else begin
                            // Step to the next byte now so GAP and START
                            // both see the byte that goes out next.
                            byte_idx <= byte_idx - 1'b1;
                            state    <= (GAP_BITS > 0) ? ST_GAP : ST_START;
                        end
                    end
                end

                ST_GAP: begin
                    if (bit_tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= '0;
                            state   <= ST_START;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Line driver. {byte_idx, bit_idx} is byte_idx*8 + bit_idx, the frame
    // bit currently on the wire; byte_idx never exceeds 17, so the index
    // stays within the 144-bit frame.
    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = frame_q[{byte_idx, bit_idx}];
            default:  tx = 1'b1;
        endcase
    end

    assign busy      = (state == ST_START) || (state == ST_DATA) ||
                       (state == ST_STOP)  || (state == ST_GAP);
    assign done      = (state == ST_DONE);
    // DONE still counts as occupied, so only IDLE may take a request.
    assign dropped   = start && (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_tx
//
// Two transmitters at 16 clocks per bit: u_dut0 without inter-byte gap,
// u_dut1 with two gap bit periods. A cycle-level reference model derives
// the expected line level from the age of the frame (clocks since
// acceptance) by plain arithmetic over the 8N1 byte layout; one compare
// process checks tx/busy/done/dropped/state of both devices every cycle.
// Literal pins fix selected waveform points, the done cycle and the busy
// lengths of the directed frames.
// ---------------------------------------------------------------------------
module tb_uart_frame_tx;
    import uart_frame_tx_pkg::*;

    localparam int BIT_CLKS = 16;

    // ---------------- clock / reset ----------------
    logic clk_ext = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_ext = ~clk_ext;

    // ---------------- DUT signals ----------------
    logic         start0, start1;
    logic [7:0]   cmd0, cmd1;
    logic [127:0] payload0, payload1;
    logic         tx0, tx1, busy0, busy1, done0, done1, dropped0, dropped1;
    logic [2:0]   state0, state1;

    uart_frame_tx #(.BR_LIMIT(1), .OVERSAMPLE(16), .GAP_BITS(0)) u_dut0 (
        .clk_ext(clk_ext), .reset(reset), .start(start0), .cmd(cmd0),
        .payload(payload0), .tx(tx0), .busy(busy0), .done(done0),
        .dropped(dropped0), .state_dbg(state0)
    );

    uart_frame_tx #(.BR_LIMIT(1), .OVERSAMPLE(16), .GAP_BITS(2)) u_dut1 (
        .clk_ext(clk_ext), .reset(reset), .start(start1), .cmd(cmd1),
        .payload(payload1), .tx(tx1), .busy(busy1), .done(done1),
        .dropped(dropped1), .state_dbg(state1)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit pin_en   = 1'b0;
    bit tb_done  = 1'b0;

    int           age [2];       // 0 = idle, n = n-th cycle after acceptance
    int           busy_cnt [2];
    logic [143:0] mframe [2];

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    // Expected line level n clocks after acceptance (n >= 1).
    function automatic logic exp_tx_at(input logic [143:0] f, input int gap, input int n);
        int idx, blen, b, off;
        idx  = n - 1;
        blen = (10 + gap) * BIT_CLKS;
        b    = idx / blen;               // bytes already sent, top byte first
        off  = idx % blen;
        if (off < BIT_CLKS) return 1'b0;
        if (off < 9 * BIT_CLKS) return f[(17 - b) * 8 + (off / BIT_CLKS - 1)];
        return 1'b1;                     // stop bit or gap
    endfunction

    // Hand-computed points of the 'A' / 0x43,0... frame; -1 = no pin.
    function automatic int pin_tx(input int n);
        case (n)
            1, 16, 33, 49, 129, 161, 209, 2721: return 0;
            17, 113, 145, 160, 177, 193, 2737, 2865, 2880: return 1;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    int   c_total, c_pin;
    bit   c_idle;
    logic c_s, c_t, c_b, c_d, c_dr, c_et, c_eb, c_ed;
    logic [2:0]   c_st;
    logic [7:0]   c_c;
    logic [127:0] c_p;

    always @(negedge clk_ext) begin
        for (int k = 0; k < 2; k++) begin
            c_s  = (k == 0) ? start0   : start1;
            c_c  = (k == 0) ? cmd0     : cmd1;
            c_p  = (k == 0) ? payload0 : payload1;
            c_t  = (k == 0) ? tx0      : tx1;
            c_b  = (k == 0) ? busy0    : busy1;
            c_d  = (k == 0) ? done0    : done1;
            c_dr = (k == 0) ? dropped0 : dropped1;
            c_st = (k == 0) ? state0   : state1;
            c_total = (180 + 17 * gap_of(k)) * BIT_CLKS;

            if (reset) begin
                age[k]      = 0;
                busy_cnt[k] = 0;
            end
            c_idle = (age[k] == 0);

            if (!c_idle && age[k] <= c_total) begin
                c_et = exp_tx_at(mframe[k], gap_of(k), age[k]);
                c_eb = 1'b1; c_ed = 1'b0;
            end else if (age[k] == c_total + 1) begin
                c_et = 1'b1; c_eb = 1'b0; c_ed = 1'b1;
            end else begin
                c_et = 1'b1; c_eb = 1'b0; c_ed = 1'b0;
            end

            chk("tx", k, 32'(c_t), 32'(c_et));
            chk("busy", k, 32'(c_b), 32'(c_eb));
            chk("done", k, 32'(c_d), 32'(c_ed));
            chk("dropped", k, 32'(c_dr), 32'(c_s && !c_idle && !reset));
            if (c_idle) chk("state_idle", k, 32'(c_st), 32'(ST_IDLE));
            if (c_ed)   chk("state_done", k, 32'(c_st), 32'(ST_DONE));

            // Literal pins on the directed frame of device 0.
            if (k == 0 && pin_en && !c_idle) begin
                c_pin = pin_tx(age[k]);
                if (c_pin >= 0) chk("pin_tx", age[k], 32'(c_t), 32'(c_pin));
                if (age[k] == 2881) chk("pin_done_2881", k, 32'(c_d), 32'd1);
            end

            if (c_b) busy_cnt[k]++;
            if (c_ed) begin
                chk("busy_len", k, 32'(busy_cnt[k]), (k == 0) ? 32'd2880 : 32'd3424);
                busy_cnt[k] = 0;
            end

            // Advance the model into the next cycle.
            if (reset) begin
                age[k] = 0;
            end else if (c_idle) begin
                if (c_s) begin
                    mframe[k] = {c_c, c_p, c_c};
                    age[k]    = 1;
                end
            end else if (age[k] == c_total + 1) begin
                age[k] = 0;
            end else begin
                age[k]++;
            end
        end

        if (tb_done) begin
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
    end

    // ---------------- driver tasks ----------------
    logic [7:0] cmd_tab [8];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_ext);
        #1;
    endtask

    task automatic send0(input logic [7:0] c, input logic [127:0] p);
        cmd0 = c; payload0 = p; start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        cmd0 = 8'($urandom); payload0 = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send1(input logic [7:0] c, input logic [127:0] p);
        cmd1 = c; payload1 = p; start1 = 1'b1;
        cyc(1);
        start1 = 1'b0;
        cmd1 = 8'($urandom); payload1 = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic poke0();
        cmd0 = 8'($urandom); payload0 = {$urandom, $urandom, $urandom, $urandom};
        start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
    endtask

    task automatic poke1();
        start1 = 1'b1;
        cyc(1);
        start1 = 1'b0;
    endtask

    function automatic logic [127:0] rnd_payload();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int off, idle;
        cmd_tab[0] = CMD_AT; cmd_tab[1] = CMD_A; cmd_tab[2] = CMD_B; cmd_tab[3] = CMD_C;
        cmd_tab[4] = CMD_D;  cmd_tab[5] = CMD_G; cmd_tab[6] = CMD_LA; cmd_tab[7] = CMD_LB;
        start0 = 1'b0; start1 = 1'b0;
        cmd0 = '0; cmd1 = '0; payload0 = '0; payload1 = '0;

        cyc(3);
        reset = 1'b0;
        cyc(2);

        // Directed 'A' frame with a refused request about 100 cycles in.
        pin_en = 1'b1;
        send0(8'h41, {8'h43, 120'h0});
        cyc(98);
        poke0();
        cyc(2880 - 99 + 3);
        pin_en = 1'b0;

        // Reset in the middle of a frame, then a full frame afterwards.
        send0(cmd_tab[$urandom_range(0, 7)], rnd_payload());
        cyc(499);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        send0(8'h44, {8'h40, 88'h0, "DEV@"});
        cyc(2885);

        // start held across DONE and the following IDLE cycle.
        send0(cmd_tab[$urandom_range(0, 7)], rnd_payload());
        cyc(2880);
        cmd0 = 8'h62; payload0 = rnd_payload(); start0 = 1'b1;
        cyc(2);
        start0 = 1'b0;
        cyc(2885);

        // Gapped device: two frames with a refused request in flight.
        for (int i = 0; i < 2; i++) begin
            send1(cmd_tab[$urandom_range(0, 7)], rnd_payload());
            off = $urandom_range(1, 3400);
            cyc(off);
            poke1();
            cyc(3424 - off + 4);
        end

        // Randomised frames, refused requests and short idle spacing.
        for (int i = 0; i < 4; i++) begin
            send0(cmd_tab[$urandom_range(0, 7)], rnd_payload());
            off  = $urandom_range(1, 2870);
            idle = $urandom_range(0, 6);
            cyc(off);
            poke0();
            cyc(2880 - off + idle);
        end
        cyc(2890);

        tb_done = 1'b1;
        cyc(4);
        $display("FAIL finish: compare process did not end the run");
        $fatal(1);
    end

endmodule
